// File: rtl/ofm_writeback_packer.sv
// OFM writeback packer: captures 16-byte PE output vectors into a small slot
// buffer and streams each slot to the OFM BRAM as four big-endian 32-bit words.
module ofm_writeback_packer #(
  parameter int ADDR_W    = 20,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_pixels,
  input  logic [15:0]       valid,
  input  logic [7:0]        OFM_0,
  input  logic [7:0]        OFM_1,
  input  logic [7:0]        OFM_2,
  input  logic [7:0]        OFM_3,
  input  logic [7:0]        OFM_4,
  input  logic [7:0]        OFM_5,
  input  logic [7:0]        OFM_6,
  input  logic [7:0]        OFM_7,
  input  logic [7:0]        OFM_8,
  input  logic [7:0]        OFM_9,
  input  logic [7:0]        OFM_10,
  input  logic [7:0]        OFM_11,
  input  logic [7:0]        OFM_12,
  input  logic [7:0]        OFM_13,
  input  logic [7:0]        OFM_14,
  input  logic [7:0]        OFM_15,
  input  logic              mem_ready,
  output logic              we_OFM,
  output logic [ADDR_W-1:0] addr_OFM,
  output logic [31:0]       data_out_OFM,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              partial_err
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef logic [3:0][31:0] slot_t;  // index k = word k of the pixel

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_req_t;

  state_t            state_q, state_d;
  slot_t             slots [BUF_DEPTH];
  slot_t             vec;
  logic [7:0]        ofm [16];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        word_q;
  logic [15:0]       pix_q, cap_q, npix_q;
  logic [ADDR_W-1:0] base_q;
  wr_req_t           wr;

  logic full, vec_full, in_run, xfer, pop, cap, last_cap, drain_end, ovf_set, part_set;

  assign ofm[0]  = OFM_0;  assign ofm[1]  = OFM_1;  assign ofm[2]  = OFM_2;  assign ofm[3]  = OFM_3;
  assign ofm[4]  = OFM_4;  assign ofm[5]  = OFM_5;  assign ofm[6]  = OFM_6;  assign ofm[7]  = OFM_7;
  assign ofm[8]  = OFM_8;  assign ofm[9]  = OFM_9;  assign ofm[10] = OFM_10; assign ofm[11] = OFM_11;
  assign ofm[12] = OFM_12; assign ofm[13] = OFM_13; assign ofm[14] = OFM_14; assign ofm[15] = OFM_15;

  // Pack four consecutive PE bytes per word, lowest PE in the MSB byte.
  for (genvar w = 0; w < 4; w++) begin : g_pack
    assign vec[w] = {ofm[4*w], ofm[4*w+1], ofm[4*w+2], ofm[4*w+3]};
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt_q == CNT_W'(BUF_DEPTH));
  assign vec_full  = (valid == 16'hFFFF);
  assign in_run    = (state_q == RUN);
  assign xfer      = wr.we && mem_ready;
  assign pop       = xfer && (word_q == 2'd3);
  // A slot frees up in the same cycle the head's last word leaves.
  assign cap       = in_run && vec_full && (!full || pop);
  assign last_cap  = cap && ((cap_q + 16'd1) == npix_q);
  assign drain_end = (state_q == DRAIN) && pop && (cnt_q == CNT_W'(1));
  assign ovf_set   = (in_run && vec_full && !cap) ||
                     (((state_q == DRAIN) || (state_q == DONE)) && (valid != 16'h0));
  assign part_set  = in_run && !vec_full && (valid != 16'h0);

  // Write request is a pure function of registered state, so it is stable
  // while mem_ready is low and forced to zero whenever the buffer is empty.
  always_comb begin
    wr      = '0;
    wr.we   = (cnt_q != '0);
    if (wr.we) begin
      wr.addr = base_q + ADDR_W'({pix_q, 2'b00}) + ADDR_W'(word_q);
      wr.data = slots[head_q][word_q];
    end
  end

  assign we_OFM       = wr.we;
  assign addr_OFM     = wr.addr;
  assign data_out_OFM = wr.data;
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start overrides every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      RUN:     if (last_cap)  state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = (num_pixels == 16'd0) ? DONE : RUN;
  end

  // Buffer bookkeeping, counters and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      pix_q       <= '0;
      cap_q       <= '0;
      npix_q      <= '0;
      base_q      <= '0;
      overflow    <= 1'b0;
      partial_err <= 1'b0;
    end else if (start) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      pix_q       <= '0;
      cap_q       <= '0;
      npix_q      <= num_pixels;
      base_q      <= base_addr;
      overflow    <= 1'b0;
      partial_err <= 1'b0;
    end else begin
      if (cap) begin
        tail_q <= ptr_inc(tail_q);
        cap_q  <= cap_q + 16'd1;
      end
      if (xfer) word_q <= word_q + 2'd1;
      if (pop) begin
        head_q <= ptr_inc(head_q);
        pix_q  <= pix_q + 16'd1;
      end
      cnt_q <= cnt_q + CNT_W'(cap) - CNT_W'(pop);
      if (ovf_set)  overflow    <= 1'b1;
      if (part_set) partial_err <= 1'b1;
    end
  end

  // Slot payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (cap) slots[tail_q] <= vec;
  end

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Directed bench for ofm_writeback_packer: hand-computed addresses/words.
module tb_ofm_writeback_packer;

  logic        clk = 1'b0;
  logic        reset, start, mem_ready;
  logic [19:0] base_addr;
  logic [15:0] num_pixels, valid;
  logic [7:0]  ofm [16];
  logic        we_OFM, busy, done, overflow, partial_err;
  logic [19:0] addr_OFM;
  logic [31:0] data_out_OFM;

  int n_vec = 0;
  int n_err = 0;
  logic [19:0] log_a[$];
  logic [31:0] log_d[$];

  always #5 clk = ~clk;

  ofm_writeback_packer #(.ADDR_W(20), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_pixels(num_pixels), .valid(valid),
    .OFM_0(ofm[0]),   .OFM_1(ofm[1]),   .OFM_2(ofm[2]),   .OFM_3(ofm[3]),
    .OFM_4(ofm[4]),   .OFM_5(ofm[5]),   .OFM_6(ofm[6]),   .OFM_7(ofm[7]),
    .OFM_8(ofm[8]),   .OFM_9(ofm[9]),   .OFM_10(ofm[10]), .OFM_11(ofm[11]),
    .OFM_12(ofm[12]), .OFM_13(ofm[13]), .OFM_14(ofm[14]), .OFM_15(ofm[15]),
    .mem_ready(mem_ready), .we_OFM(we_OFM), .addr_OFM(addr_OFM),
    .data_out_OFM(data_out_OFM), .busy(busy), .done(done),
    .overflow(overflow), .partial_err(partial_err)
  );

  // Record every accepted write; inputs only change just after posedge.
  always @(negedge clk) begin
    if (we_OFM && mem_ready) begin
      log_a.push_back(addr_OFM);
      log_d.push_back(data_out_OFM);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] b0, input int k);
    logic [7:0] b;
    b = b0 + 8'(4 * k);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [19:0] ba, input logic [15:0] np);
    base_addr = ba; num_pixels = np; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] v, input logic [7:0] b0);
    valid = v;
    for (int i = 0; i < 16; i++) ofm[i] = b0 + 8'(i);
    tick();
    valid = 16'h0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int n);
    for (int i = 0; i < 200 && log_a.size() < n; i++) @(negedge clk);
    chk(tag, log_a.size(), n);
  endtask

  // Check 4 logged words of one pixel starting at log index idx.
  task automatic chk_pix(input string tag, input int idx, input logic [19:0] a0, input logic [7:0] b0);
    for (int k = 0; k < 4; k++) begin
      if (idx + k < log_a.size()) begin
        chk({tag, "_addr"}, 32'(log_a[idx+k]), 32'(a0 + 20'(k)));
        chk({tag, "_data"}, log_d[idx+k], exp_word(b0, k));
      end else begin
        chk({tag, "_missing"}, 32'(log_a.size()), 32'(idx + k + 1));
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b1; valid = 16'h0;
    base_addr = '0; num_pixels = '0;
    for (int i = 0; i < 16; i++) ofm[i] = 8'h0;
    tick(); tick();
    chk("rst_we", 32'(we_OFM), 0);
    chk("rst_addr", 32'(addr_OFM), 0);
    chk("rst_data", data_out_OFM, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_flags", {30'd0, overflow, partial_err}, 0);
    reset = 1'b0;
    tick();

    // Basic two-pixel run.
    log_a.delete(); log_d.delete();
    do_start(20'h100, 16'd2);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_we_after_start", 32'(we_OFM), 0);
    send_vec(16'hFFFF, 8'h00);
    send_vec(16'hFFFF, 8'h10);
    wait_done("t1_done");
    chk("t1_nwrites", log_a.size(), 8);
    chk("t1_first", log_d.size() > 0 ? log_d[0] : 32'hDEAD, 32'h00010203);
    chk("t1_last", log_d.size() > 7 ? log_d[7] : 32'hDEAD, 32'h1C1D1E1F);
    chk_pix("t1_p0", 0, 20'h100, 8'h00);
    chk_pix("t1_p1", 4, 20'h104, 8'h10);
    @(negedge clk);
    chk("t1_done_1cyc", 32'(done), 0);
    chk("t1_flags", {30'd0, overflow, partial_err}, 0);
    tick();

    // Backpressure in the middle of a pixel.
    log_a.delete(); log_d.delete();
    do_start(20'h0, 16'd1);
    send_vec(16'hFFFF, 8'h40);
    tick();                        // word 0 transfers here
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_we", 32'(we_OFM), 1);
      chk("t2_hold_addr", 32'(addr_OFM), 32'h1);
      chk("t2_hold_data", data_out_OFM, 32'h44454647);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    wait_done("t2_done");
    chk("t2_nwrites", log_a.size(), 4);
    chk_pix("t2_p0", 0, 20'h0, 8'h40);
    tick();

    // Overflow with the buffer full and no drain.
    log_a.delete(); log_d.delete();
    mem_ready = 1'b0;
    do_start(20'h200, 16'd3);
    send_vec(16'hFFFF, 8'h20);
    send_vec(16'hFFFF, 8'h40);
    send_vec(16'hFFFF, 8'h60);     // dropped
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_no_write", log_a.size(), 0);
    mem_ready = 1'b1;
    wait_log("t3_resume", 8);
    chk_pix("t3_p0", 0, 20'h200, 8'h20);
    chk_pix("t3_p1", 4, 20'h204, 8'h40);
    chk("t3_busy", 32'(busy), 1);
    tick();
    send_vec(16'hFFFF, 8'h80);
    wait_done("t3_done");
    chk_pix("t3_p2", 8, 20'h208, 8'h80);
    chk("t3_ovf_sticky", 32'(overflow), 1);
    tick();

    // Partial valid: flagged, not captured, sticky until start.
    log_a.delete(); log_d.delete();
    do_start(20'h0, 16'd1);
    send_vec(16'h00FF, 8'hA0);
    chk("t4_partial", 32'(partial_err), 1);
    chk("t4_no_cap", 32'(we_OFM), 0);
    send_vec(16'hFFFF, 8'hB0);
    wait_done("t4_done");
    chk("t4_nwrites", log_a.size(), 4);
    chk("t4_sticky", 32'(partial_err), 1);
    tick();

    // Address wrap at the top of the address space.
    log_a.delete(); log_d.delete();
    do_start(20'hFFFFE, 16'd1);
    chk("t5_partial_clr", 32'(partial_err), 0);
    send_vec(16'hFFFF, 8'hC0);
    wait_done("t5_done");
    chk("t5_nwrites", log_a.size(), 4);
    chk("t5_a0", log_a.size() > 0 ? 32'(log_a[0]) : 32'hDEAD, 32'hFFFFE);
    chk("t5_a1", log_a.size() > 1 ? 32'(log_a[1]) : 32'hDEAD, 32'hFFFFF);
    chk("t5_a2", log_a.size() > 2 ? 32'(log_a[2]) : 32'hDEAD, 32'h00000);
    chk("t5_a3", log_a.size() > 3 ? 32'(log_a[3]) : 32'hDEAD, 32'h00001);
    tick();

    // Reset in the middle of a pixel, then an empty run.
    do_start(20'h300, 16'd1);
    send_vec(16'hFFFF, 8'hD0);
    tick();                        // word 0 transfers, word 1 presented
    chk("t6_pre_addr", 32'(addr_OFM), 32'h301);
    reset = 1'b1;
    #2;
    chk("t6_we", 32'(we_OFM), 0);
    chk("t6_addr", 32'(addr_OFM), 0);
    chk("t6_data", data_out_OFM, 0);
    chk("t6_status", {28'd0, busy, done, overflow, partial_err}, 0);
    tick();
    reset = 1'b0;
    log_a.delete(); log_d.delete();
    repeat (5) tick();
    chk("t6_no_write", log_a.size(), 0);
    do_start(20'h0, 16'd0);
    chk("t6_done_zero", 32'(done), 1);
    tick();
    chk("t6_done_gone", 32'(done), 0);
    repeat (4) tick();
    chk("t6_zero_nowrite", log_a.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ofm_writeback_packer.md
OFM_WRITEBACK_PACKER -- requirements
Module: ofm_writeback_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, OFM BRAM word-address width.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, number of 16-byte capture slots.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; latches base_addr/num_pixels, clears counters and flags.
REQ-006 SHALL have port base_addr  input  ADDR_W  first OFM word address.
REQ-007 SHALL have port num_pixels  input  16  output vectors to collect per run (56x56 layer = 3136).
REQ-008 SHALL have port valid  input  16  per-PE valid from the conv array.
REQ-009 SHALL have ports OFM_0..OFM_15  input  8 each  per-PE output byte.
REQ-010 SHALL have port mem_ready  input  1  OFM BRAM accepts a write this cycle.
REQ-011 SHALL have port we_OFM  output  1  write request.
REQ-012 SHALL have port addr_OFM  output  ADDR_W  write word address.
REQ-013 SHALL have port data_out_OFM  output  32  write data.
REQ-014 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port overflow  output  1  sticky; capture dropped.
REQ-017 SHALL have port partial_err  output  1  sticky; valid neither 0 nor 16'hFFFF.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-019 IDLE: valid ignored; start -> RUN.
REQ-020 start in any state SHALL flush buffer, zero pixel/word counters, clear overflow and partial_err, enter RUN; we_OFM low the following cycle.
REQ-021 start with num_pixels=0 SHALL go to DONE (done high cycle after start), no writes.
REQ-022 RUN: valid==16'hFFFF at an edge SHALL capture {OFM_0..OFM_15} into the tail slot if a slot is free, else set overflow and drop the vector.
REQ-023 A slot counts free if buffer not full or the head's 4th word transfers in the same cycle.
REQ-024 Valid not in {0, 16'hFFFF} in RUN SHALL set partial_err; no capture.
REQ-025 Accepted captures SHALL increment capture count; reaching num_pixels -> DRAIN; further valid in DRAIN/DONE sets overflow.
REQ-026 Each slot SHALL emit 4 words: word k = {OFM_4k, OFM_4k+1, OFM_4k+2, OFM_4k+3}, OFM_4k in bits [31:24].
REQ-027 addr_OFM = base_addr + 4*pixel_index + k, modulo 2^ADDR_W (wraps silently).
REQ-028 Transfer occurs only when we_OFM and mem_ready both high; while mem_ready low, we_OFM/addr_OFM/data_out_OFM SHALL hold stable.
REQ-029 Latency: capture at edge N -> we_OFM high with word 0 after edge N (registered output), given buffer previously empty.
REQ-030 Sustained throughput SHALL be one word per cycle with mem_ready held high.
REQ-031 DRAIN: after last word of last pixel transfers -> DONE; DONE lasts one cycle (done=1) -> IDLE.
REQ-032 we_OFM SHALL be 0 whenever the buffer is empty.

Reset
REQ-033 reset SHALL immediately force IDLE, empty buffer, zero counters; we_OFM, addr_OFM, data_out_OFM, busy, done, overflow, partial_err all 0.
REQ-034 Reset mid-RUN SHALL discard pending words; no write after reset deassertion until a new start.

Verification
REQ-035 base_addr=0x100, num_pixels=2, two valid=FFFF vectors with OFM_i=i and i+0x10, mem_ready=1 -> 8 writes 0x100..0x107, first 0x00010203, last 0x1C1D1E1F; done one pulse; flags 0.
REQ-036 mem_ready low 5 cycles mid-pixel -> we_OFM/addr/data stable 5 cycles; no word lost or duplicated.
REQ-037 mem_ready=0, three FFFF vectors back-to-back -> first two buffered, overflow=1, third dropped, writes resume with pixel 0 when mem_ready rises.
REQ-038 valid=16'h00FF for one cycle in RUN -> partial_err=1, no capture, cleared only by start/reset.
REQ-039 base_addr=0xFFFFE, num_pixels=1 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
REQ-040 reset asserted during 2nd word of a pixel -> all outputs 0 next sample; later start with num_pixels=0 -> done next cycle, no writes.
